// File: rtl/ts_pkg.sv
// Shared definitions for the TS packet multiplexer.
//   TS_SYNC_BYTE  : MPEG-TS sync byte
//   NULL_HDR      : 4-byte header of a null packet (PID 0x1FFF)
//   NULL_FILL     : payload fill byte of a null packet
//   PKT_LEN_188/204 : legal packet lengths
//   ts_state_e    : arbiter FSM state encoding
//   null_byte()   : byte of a null packet at a given position
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam logic [31:0] NULL_HDR     = {8'h47, 8'h1F, 8'hFF, 8'h10};
    localparam logic [7:0]  NULL_FILL    = 8'hFF;
    localparam int          PKT_LEN_188  = 188;
    localparam int          PKT_LEN_204  = 204;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_SEND = 2'd1,
        ST_NULL = 2'd2,
        ST_GAP  = 2'd3
    } ts_state_e;

    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        logic [7:0] b;
        case (idx)
            8'd0:    b = NULL_HDR[31:24];
            8'd1:    b = NULL_HDR[23:16];
            8'd2:    b = NULL_HDR[15:8];
            8'd3:    b = NULL_HDR[7:0];
            default: b = NULL_FILL;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant selection.
//   eligible  : request vector (ready & mask)
//   rr_ptr    : last granted channel; search starts at rr_ptr+1 (mod N_CH)
//   grant     : index of the winning channel (valid when grant_vld)
//   grant_vld : at least one channel is eligible
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CW   = 2
) (
    input  logic [N_CH-1:0] eligible,
    input  logic [CW-1:0]   rr_ptr,
    output logic [CW-1:0]   grant,
    output logic            grant_vld
);

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            int              idx;
            logic [N_CH-1:0] elig_sh;
            idx     = (int'(rr_ptr) + i) % N_CH;
            elig_sh = eligible >> idx;
            if (!grant_vld && elig_sh[0]) begin
                grant_vld = 1'b1;
                grant     = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/ts_packet_arbiter.sv
// N-channel TS packet multiplexer on the clk_27 output domain. Pulls whole
// packets from show-ahead FIFOs round-robin, optionally stuffs null packets,
// and drives the parallel TS output directly.
//   clk_27, RST    : clock, async active-low reset
//   ch_pkt_ready   : per-channel "FIFO holds a full packet"
//   ch_data        : per-channel FIFO q, channel k at [8k+7:8k]
//   ch_rd_en       : one-hot FIFO pop (combinational from state)
//   ch_mask        : per-channel arbitration enable
//   null_en        : stuff null packets when nothing is eligible
//   data_out, d_valid_out, p_sync_out : registered TS output
//   cur_ch, null_active : packet-in-flight info
//   sync_err       : pulse when a channel packet did not start with 0x47
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_ARB  | pick next channel (1 cycle), or go stuff a null, or idle
// ST_SEND | stream PKT_LEN bytes from cur_ch
// ST_NULL | stream a generated null packet
// ST_GAP  | forced idle for GAP_CYCLES cycles
module ts_packet_arbiter
    import ts_pkg::*;
#(
    parameter  int N_CH       = 4,
    parameter  int PKT_LEN    = PKT_LEN_188,
    parameter  int GAP_CYCLES = 0,
    localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_27,
    input  logic              RST,
    input  logic [N_CH-1:0]   ch_pkt_ready,
    input  logic [8*N_CH-1:0] ch_data,
    output logic [N_CH-1:0]   ch_rd_en,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic              null_en,
    output logic [7:0]        data_out,
    output logic              d_valid_out,
    output logic              p_sync_out,
    output logic [CW-1:0]     cur_ch,
    output logic              null_active,
    output logic              sync_err
);

    if (PKT_LEN < 1 || PKT_LEN > 255) begin : g_bad_pkt_len
        $error("ts_packet_arbiter: PKT_LEN must fit the 8-bit byte counter");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("ts_packet_arbiter: GAP_CYCLES out of range 0..255");
    end
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("ts_packet_arbiter: N_CH out of range 1..16");
    end

    localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES);

    ts_state_e   state_q, state_d;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cur_ch_q, cur_ch_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        d_valid_q, d_valid_d;
    logic        p_sync_q, p_sync_d;
    logic        null_active_q, null_active_d;
    logic        sync_err_q, sync_err_d;

    logic [N_CH-1:0] eligible;
    logic [CW-1:0]   grant;
    logic            grant_vld;
    logic [7:0]      sel_byte;
    logic            last_byte;

    assign eligible  = ch_pkt_ready & ch_mask;
    assign last_byte = (byte_cnt_q == LAST_BYTE);

    rr_arbiter #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_rr_arbiter (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch_q == CW'(k)) sel_byte = ch_data[8*k +: 8];
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cur_ch_d      = cur_ch_q;
        byte_cnt_d    = byte_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        data_out_d    = '0;
        d_valid_d     = 1'b0;
        p_sync_d      = 1'b0;
        null_active_d = 1'b0;
        sync_err_d    = 1'b0;
        ch_rd_en      = '0;

        case (state_q)
            ST_ARB: begin
                byte_cnt_d = '0;
                if (grant_vld) begin
                    cur_ch_d = grant;
                    rr_ptr_d = grant;
                    state_d  = ST_SEND;
                end else if (null_en) begin
                    state_d = ST_NULL;
                end
            end
            ST_SEND: begin
                ch_rd_en  = N_CH'(1) << cur_ch_q;
                d_valid_d = 1'b1;
                p_sync_d  = (byte_cnt_q == 8'd0);
                // A bad first byte is replaced so downstream stays locked.
                if (byte_cnt_q == 8'd0 && sel_byte != TS_SYNC_BYTE) begin
                    data_out_d = TS_SYNC_BYTE;
                    sync_err_d = 1'b1;
                end else begin
                    data_out_d = sel_byte;
                end
                if (last_byte) begin
                    byte_cnt_d = '0;
                    gap_cnt_d  = GAP_LOAD;
                    state_d    = (GAP_CYCLES > 0) ? ST_GAP : ST_ARB;
                end else begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                end
            end
            ST_NULL: begin
                d_valid_d     = 1'b1;
                p_sync_d      = (byte_cnt_q == 8'd0);
                null_active_d = 1'b1;
                data_out_d    = null_byte(byte_cnt_q);
                if (last_byte) begin
                    byte_cnt_d = '0;
                    gap_cnt_d  = GAP_LOAD;
                    state_d    = (GAP_CYCLES > 0) ? ST_GAP : ST_ARB;
                end else begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 8'd1) begin
                    state_d = ST_ARB;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk_27 or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_ARB;
            rr_ptr_q      <= CW'(N_CH - 1);
            cur_ch_q      <= '0;
            byte_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            data_out_q    <= '0;
            d_valid_q     <= 1'b0;
            p_sync_q      <= 1'b0;
            null_active_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cur_ch_q      <= cur_ch_d;
            byte_cnt_q    <= byte_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            data_out_q    <= data_out_d;
            d_valid_q     <= d_valid_d;
            p_sync_q      <= p_sync_d;
            null_active_q <= null_active_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign data_out    = data_out_q;
    assign d_valid_out = d_valid_q;
    assign p_sync_out  = p_sync_q;
    assign cur_ch      = cur_ch_q;
    assign null_active = null_active_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_ts_packet_arbiter.sv
module tb_ts_packet_arbiter;

    localparam int N   = 4;
    localparam int PL  = 188;
    localparam int PLB = 204;

    logic clk_27 = 1'b0;
    always #18 clk_27 = ~clk_27;
    logic RST;

    // instance A: N=4, 188 bytes, no gap
    logic [N-1:0]   ch_pkt_ready = '0;
    logic [8*N-1:0] ch_data      = '0;
    logic [N-1:0]   ch_rd_en;
    logic [N-1:0]   ch_mask;
    logic           null_en;
    logic [7:0]     data_out;
    logic           d_valid_out, p_sync_out, null_active, sync_err;
    logic [1:0]     cur_ch;

    // instance B: N=4, 204 bytes, 3 gap cycles
    logic [N-1:0]   ready_b = '0;
    logic [8*N-1:0] data_b  = '0;
    logic [N-1:0]   rd_en_b;
    logic [N-1:0]   mask_b;
    logic           null_en_b;
    logic [7:0]     data_out_b;
    logic           valid_b, psync_b, null_act_b, serr_b;
    logic [1:0]     cur_ch_b;

    ts_packet_arbiter #(.N_CH(N), .PKT_LEN(PL), .GAP_CYCLES(0)) u_dut (
        .clk_27(clk_27), .RST(RST), .ch_pkt_ready(ch_pkt_ready), .ch_data(ch_data),
        .ch_rd_en(ch_rd_en), .ch_mask(ch_mask), .null_en(null_en), .data_out(data_out),
        .d_valid_out(d_valid_out), .p_sync_out(p_sync_out), .cur_ch(cur_ch),
        .null_active(null_active), .sync_err(sync_err)
    );

    ts_packet_arbiter #(.N_CH(N), .PKT_LEN(PLB), .GAP_CYCLES(3)) u_dut_b (
        .clk_27(clk_27), .RST(RST), .ch_pkt_ready(ready_b), .ch_data(data_b),
        .ch_rd_en(rd_en_b), .ch_mask(mask_b), .null_en(null_en_b), .data_out(data_out_b),
        .d_valid_out(valid_b), .p_sync_out(psync_b), .cur_ch(cur_ch_b),
        .null_active(null_act_b), .sync_err(serr_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [7:0] pbyte(input int ch, input int id, input int i);
        return 8'((ch * 37 + id * 11 + i * 3) & 255);
    endfunction

    function automatic logic [7:0] nbyte(input int i);
        case (i)
            0:       return 8'h47;
            1:       return 8'h1F;
            2:       return 8'hFF;
            3:       return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    // ---------------- channel FIFO model for instance A ----------------
    logic [7:0] fq [N][$];
    logic [N-1:0] pend_a = '0;

    always @(negedge clk_27) begin
        pend_a = ch_rd_en;
        if ($countones(ch_rd_en) > 1) flag("rd_en_onehot");
    end

    always @(posedge clk_27) begin
        #1;
        if (!RST) begin
            for (int k = 0; k < N; k++) fq[k].delete();
        end else begin
            for (int k = 0; k < N; k++) begin
                if (pend_a[k]) begin
                    if (fq[k].size() == 0) flag("fifo_underflow");
                    else void'(fq[k].pop_front());
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            ch_pkt_ready[k]   = (fq[k].size() >= PL);
            ch_data[8*k +: 8] = (fq[k].size() > 0) ? fq[k][0] : 8'h00;
        end
    end

    task automatic load_pkt(input int ch, input int id, input logic [7:0] b0);
        for (int i = 0; i < PL; i++) fq[ch].push_back(i == 0 ? b0 : pbyte(ch, id, i));
    endtask

    // ---------------- scoreboard for instance A ----------------
    typedef struct {
        logic [7:0] data;
        logic       psync;
        logic       nul;
        logic       serr;
        int         ch;
        int         gap;
    } exp_t;
    exp_t exp_q[$];

    task automatic expect_pkt(input int ch, input int id, input logic [7:0] b0, input int gap);
        exp_t e;
        for (int i = 0; i < PL; i++) begin
            e.data  = (i == 0) ? 8'h47 : pbyte(ch, id, i);
            e.psync = (i == 0);
            e.nul   = 1'b0;
            e.serr  = (i == 0) && (b0 != 8'h47);
            e.ch    = ch;
            e.gap   = (i == 0) ? gap : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_null(input int gap);
        exp_t e;
        for (int i = 0; i < PL; i++) begin
            e.data  = nbyte(i);
            e.psync = (i == 0);
            e.nul   = 1'b1;
            e.serr  = 1'b0;
            e.ch    = -1;
            e.gap   = (i == 0) ? gap : -1;
            exp_q.push_back(e);
        end
    endtask

    exp_t e_a;
    int   idle_a = 0;

    always @(negedge clk_27) begin
        if (!RST) begin
            idle_a = 0;
        end else if (d_valid_out) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_byte");
            end else begin
                e_a = exp_q.pop_front();
                check("data", data_out, e_a.data);
                check("p_sync", p_sync_out, e_a.psync);
                check("null_active", null_active, e_a.nul);
                check("sync_err", sync_err, e_a.serr);
                if (e_a.ch >= 0) check("cur_ch", cur_ch, e_a.ch);
                if (e_a.psync && e_a.gap >= 0) check("idle_gap", idle_a, e_a.gap);
            end
            idle_a = 0;
        end else begin
            idle_a++;
            if (sync_err || p_sync_out || null_active) flag("flag_while_idle");
        end
    end

    // ---------------- source + monitor for instance B ----------------
    int b_req = 0;
    int b_cnt = 0;
    logic [N-1:0] pend_b = '0;

    always @(negedge clk_27) pend_b = rd_en_b;

    always @(posedge clk_27) begin
        #1;
        if (pend_b[0]) begin
            if (b_cnt >= b_req * PLB) flag("b_fifo_underflow");
            b_cnt++;
        end
        if (pend_b[3:1] != 3'b000) flag("b_wrong_channel");
        ready_b     = (b_req * PLB - b_cnt >= PLB) ? 4'b0001 : 4'b0000;
        data_b[7:0] = (b_cnt % PLB == 0) ? 8'h47 : 8'(b_cnt % PLB);
    end

    int gap_b_q[$];
    int idle_b = 0;
    int idx_b  = 0;
    int pkts_b = 0;
    int g_b;

    always @(negedge clk_27) begin
        if (!RST) begin
            idle_b = 0;
            idx_b  = 0;
        end else if (valid_b) begin
            check("b_data", data_out_b, (idx_b == 0) ? 8'h47 : 8'(idx_b));
            check("b_p_sync", psync_b, (idx_b == 0) ? 1 : 0);
            if (idx_b == 0) begin
                if (gap_b_q.size() == 0) begin
                    flag("b_unexpected_packet");
                end else begin
                    g_b = gap_b_q.pop_front();
                    if (g_b >= 0) check("b_idle_gap", idle_b, g_b);
                end
            end
            idle_b = 0;
            idx_b++;
            if (idx_b == PLB) begin
                idx_b = 0;
                pkts_b++;
            end
        end else begin
            idle_b++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_drain(input int max_cycles);
        int t = 0;
        while (exp_q.size() != 0 && t < max_cycles) begin
            @(negedge clk_27);
            t++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (10) @(negedge clk_27);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_d_valid"}, d_valid_out, 0);
        check({tag, "_p_sync"}, p_sync_out, 0);
        check({tag, "_cur_ch"}, cur_ch, 0);
        check({tag, "_null_active"}, null_active, 0);
        check({tag, "_sync_err"}, sync_err, 0);
        check({tag, "_rd_en"}, ch_rd_en, 0);
    endtask

    initial begin
        #720000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int saw;
        RST       = 1'b0;
        ch_mask   = '0;
        null_en   = 1'b0;
        mask_b    = 4'hF;
        null_en_b = 1'b0;
        repeat (3) @(negedge clk_27);
        check_outputs_zero("reset");
        check("reset_b_valid", valid_b, 0);
        @(negedge clk_27);
        RST = 1'b1;
        repeat (3) @(negedge clk_27);

        // 1: all four ready -> 0,1,2,3,0 with one idle cycle between packets
        load_pkt(0, 0, 8'h47);
        load_pkt(1, 0, 8'h47);
        load_pkt(2, 0, 8'h47);
        load_pkt(3, 0, 8'h47);
        load_pkt(0, 1, 8'h47);
        expect_pkt(0, 0, 8'h47, -1);
        expect_pkt(1, 0, 8'h47, 1);
        expect_pkt(2, 0, 8'h47, 1);
        expect_pkt(3, 0, 8'h47, 1);
        expect_pkt(0, 1, 8'h47, 1);
        ch_mask = 4'hF;
        wait_drain(3000);

        // 2: only ch2 ready, null stuffing once it empties
        load_pkt(2, 1, 8'h47);
        load_pkt(2, 2, 8'h47);
        expect_pkt(2, 1, 8'h47, -1);
        expect_pkt(2, 2, 8'h47, 1);
        expect_null(1);
        @(negedge clk_27);
        @(negedge clk_27);
        null_en = 1'b1;
        t = 0;
        while (!null_active && t < 1500) begin
            @(negedge clk_27);
            t++;
        end
        check("null_seen", null_active, 1);
        null_en = 1'b0;
        wait_drain(1000);

        // 3: ch2 ready but masked off -> nothing happens
        ch_mask = 4'b1011;
        load_pkt(2, 3, 8'h47);
        saw = 0;
        repeat (300) begin
            @(negedge clk_27);
            if (ch_rd_en != 0 || d_valid_out) saw = 1;
        end
        check("masked_idle", saw, 0);
        expect_pkt(2, 3, 8'h47, -1);
        ch_mask = 4'hF;
        wait_drain(600);

        // 4: ch1 packet with bad sync byte
        load_pkt(1, 4, 8'h46);
        expect_pkt(1, 4, 8'h46, -1);
        wait_drain(600);

        // 5: instance B, 204-byte packets with 3 gap cycles
        gap_b_q.push_back(-1);
        gap_b_q.push_back(4);
        b_req = 2;
        t = 0;
        while (pkts_b < 2 && t < 1500) begin
            @(negedge clk_27);
            t++;
        end
        check("b_packets", pkts_b, 2);
        check("b_gap_left", gap_b_q.size(), 0);
        repeat (10) @(negedge clk_27);

        // 6: reset in the middle of a packet
        load_pkt(2, 5, 8'h47);
        expect_pkt(2, 5, 8'h47, -1);
        t = 0;
        while (exp_q.size() > PL - 100 && t < 1000) begin
            @(negedge clk_27);
            t++;
        end
        check("pre_reset_ch", cur_ch, 2);
        RST = 1'b0;
        #1;
        check_outputs_zero("midpkt_rst");
        @(negedge clk_27);
        exp_q.delete();
        check("rst_hold_valid", d_valid_out, 0);
        check("rst_hold_rd_en", ch_rd_en, 0);
        @(negedge clk_27);
        RST = 1'b1;
        @(negedge clk_27);
        check("fifo_flushed", fq[2].size(), 0);
        load_pkt(3, 6, 8'h47);
        load_pkt(1, 6, 8'h47);
        load_pkt(0, 6, 8'h47);
        expect_pkt(0, 6, 8'h47, -1);
        expect_pkt(1, 6, 8'h47, 1);
        expect_pkt(3, 6, 8'h47, 1);
        wait_drain(2000);
        check("fifo_left", fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
